btn_autorepeat: RTL and testbench

Single-channel press-to-pulse converter with hold-to-repeat. It sits between a debounce stage and the gray-code counter's UP/DOWN inputs, one instance per button. It turns a clean button level into single-cycle step pulses: one pulse on press, then periodic pulses while the button stays held.

---
 rtl/btn_autorepeat.sv | 91 +++++++++
 tb/tb_btn_autorepeat.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/btn_autorepeat.sv
// rtl/btn_autorepeat.sv - press-to-pulse converter with hold-to-repeat
module btn_autorepeat #(
  parameter int DELAY  = 62500000,
  parameter int REPEAT = 12500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTNIN,
  output logic PULSE,
  output logic HELD
);

  localparam int MAXC = (DELAY > REPEAT) ? DELAY : REPEAT;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REPEAT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          prev;
  logic          pulse_nx;

  // prev resets high so a button held through reset must be released before it fires
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      PULSE <= 1'b0;
      prev  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      PULSE <= pulse_nx;
      prev  <= BTNIN;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pulse_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (BTNIN && !prev) begin
          pulse_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!BTNIN) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (cnt == DELAY_LAST) begin
          pulse_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = S_REPEAT;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_REPEAT: begin
        if (!BTNIN) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (cnt == REPEAT_LAST) begin
          pulse_nx = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign HELD = (state == S_REPEAT);

endmodule

// File: tb/tb_btn_autorepeat.sv
// tb/tb_btn_autorepeat.sv - self-checking bench for btn_autorepeat
module tb_btn_autorepeat;

  localparam int DELAY  = 8;
  localparam int REPEAT = 3;

  logic CLK = 1'b0;
  logic RST;
  logic BTNIN;
  logic PULSE;
  logic HELD;

  int checks = 0;
  int errors = 0;

  // reference: time since the accepted press edge decides every output
  bit m_active = 1'b0;
  bit m_prev   = 1'b1;
  int m_k      = 0;
  int npulse   = 0;

  btn_autorepeat #(.DELAY(DELAY), .REPEAT(REPEAT)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .BTNIN(BTNIN),
    .PULSE(PULSE),
    .HELD (HELD)
  );

  always #5 CLK = ~CLK;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic r);
    logic exp_pulse;
    logic exp_held;
    BTNIN = b;
    RST   = r;
    @(posedge CLK);
    if (r) begin
      m_active = 1'b0;
      m_prev   = 1'b1;
    end else begin
      if (m_active && !b) m_active = 1'b0;
      else if (m_active) m_k++;
      else if (b && !m_prev) begin
        m_active = 1'b1;
        m_k      = 0;
      end
      m_prev = b;
    end
    exp_pulse = m_active && (m_k == 0 || (m_k >= DELAY && (m_k - DELAY) % REPEAT == 0));
    exp_held  = m_active && (m_k >= DELAY);
    #1;
    check_bit("pulse", PULSE, exp_pulse);
    check_bit("held", HELD, exp_held);
    if (PULSE === 1'b1) npulse++;
  endtask

  task automatic run(input logic b, input logic r, input int n);
    for (int i = 0; i < n; i++) step(b, r);
  endtask

  initial begin
    run(1'b0, 1'b1, 3);
    npulse = 0;
    run(1'b0, 1'b0, 20);
    check_int("idle_pulses", npulse, 0);

    npulse = 0;
    run(1'b1, 1'b0, 5);
    run(1'b0, 1'b0, 6);
    check_int("short_press_pulses", npulse, 1);

    npulse = 0;
    run(1'b1, 1'b0, 20);
    check_bit("long_hold_held", HELD, 1'b1);
    run(1'b0, 1'b0, 6);
    check_int("long_hold_pulses", npulse, 5);

    npulse = 0;
    run(1'b1, 1'b0, DELAY);
    run(1'b0, 1'b0, 6);
    check_int("release_at_delay_pulses", npulse, 1);

    npulse = 0;
    run(1'b1, 1'b0, DELAY + 1);
    run(1'b0, 1'b0, 6);
    check_int("release_after_delay_pulses", npulse, 2);

    run(1'b1, 1'b0, 4);
    npulse = 0;
    run(1'b1, 1'b1, 3);
    run(1'b1, 1'b0, 15);
    check_int("held_through_reset_pulses", npulse, 0);
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 3);
    check_int("repress_after_reset_pulses", npulse, 1);
    run(1'b0, 1'b0, 5);

    npulse = 0;
    run(1'b1, 1'b0, 13);
    check_int("mid_hold_pulses", npulse, 3);
    run(1'b1, 1'b1, 1);
    check_bit("mid_reset_held", HELD, 1'b0);
    npulse = 0;
    run(1'b1, 1'b0, 15);
    check_int("after_mid_reset_pulses", npulse, 0);
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 2);
    check_int("repress_after_mid_reset", npulse, 1);
    run(1'b0, 1'b0, 3);

    for (int seg = 0; seg < 300; seg++) begin
      logic b;
      logic r;
      int   len;
      b   = 1'($urandom_range(1, 0));
      r   = ($urandom_range(19, 0) == 0);
      len = r ? int'($urandom_range(2, 1)) : int'($urandom_range(20, 1));
      run(b, r, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
